// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD FSMD.
// Optional iteration counter is enabled with GCD_ITER_COUNT_EN.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_fsmd_if.sv
// Handshake/operand bus between a host sequencer and gcd_fsmd.
// iter_count exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_fsmd_if import gcd_pkg::*; #(
  parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_count;
`endif

  modport master (
    output start,
    output data_in,
    input  busy,
    input  done,
    input  result
`ifdef GCD_ITER_COUNT_EN
    , input iter_count
`endif
  );

  modport slave (
    input  start,
    input  data_in,
    output busy,
    output done,
    output result
`ifdef GCD_ITER_COUNT_EN
    , output iter_count
`endif
  );

endinterface

// File: rtl/gcd_fsmd_pipo_n.sv
// Parallel-in/parallel-out WIDTH-bit register with load enable and
// synchronous active-high reset; holds the A, B and result values.
module pipo_n #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/gcd_fsmd.sv
// Subtractive GCD controller + datapath; operands arrive serially on data_in.
// Define GCD_ITER_COUNT_EN to add the saturating subtraction counter.
module gcd_fsmd import gcd_pkg::*; #(
  parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  gcd_fsmd_if.slave  bus
);

  gcd_state_e       state_d, state_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             a_ld, b_ld, res_ld;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;

  pipo_n #(.WIDTH(WIDTH)) u_reg_a   (.clk(clk), .rst(rst), .ld(a_ld),   .d(a_d),   .q(a_q));
  pipo_n #(.WIDTH(WIDTH)) u_reg_b   (.clk(clk), .rst(rst), .ld(b_ld),   .d(b_d),   .q(b_q));
  pipo_n #(.WIDTH(WIDTH)) u_reg_res (.clk(clk), .rst(rst), .ld(res_ld), .d(res_d), .q(res_q));

  // Controller and compare/subtract datapath
  always_comb begin
    state_d = state_q;
    a_ld    = 1'b0;
    b_ld    = 1'b0;
    res_ld  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = a_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_ld    = 1'b1;
          a_d     = bus.data_in;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        b_ld    = 1'b1;
        b_d     = bus.data_in;
        state_d = CALC;
      end
      CALC: begin
        if (a_q == '0) begin
          res_ld  = 1'b1;
          res_d   = b_q;
          state_d = DONE;
        end else if (b_q == '0 || a_q == b_q) begin
          res_ld  = 1'b1;
          res_d   = a_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_ld = 1'b1;
          a_d  = a_q - b_q;
        end else begin
          b_ld = 1'b1;
          b_d  = b_q - a_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOAD_B) || (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iter_d, iter_q;
  logic             sub_en;

  // Counts subtraction edges, cleared on an accepted start, saturating
  always_comb begin
    sub_en = (state_q == CALC) && (a_q != '0) && (b_q != '0) && (a_q != b_q);
    iter_d = iter_q;
    if (state_q == IDLE && bus.start)      iter_d = '0;
    else if (sub_en && (iter_q != '1))     iter_d = iter_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) iter_q <= '0;
    else     iter_q <= iter_d;
  end

  assign bus.iter_count = iter_q;
`endif

endmodule

// File: tb/tb_gcd_fsmd.sv
// Bench for gcd_fsmd: 16-bit and 4-bit instances checked every cycle against
// a timeline model, plus hand-computed per-run expectations.
module tb_gcd_fsmd;

  localparam int unsigned MASK0 = 32'h0000_FFFF;
  localparam int unsigned MASK1 = 32'h0000_000F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_fsmd_if #(.WIDTH(16)) bus16 ();
  gcd_fsmd_if #(.WIDTH(4))  bus4  ();

  gcd_fsmd #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  gcd_fsmd #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  logic        st  [2];
  logic [15:0] din [2];
  logic        busy_o [2];
  logic        done_o [2];
  int unsigned res_o  [2];
  int unsigned iter_o [2];

  assign bus16.start   = st[0];
  assign bus16.data_in = din[0];
  assign bus4.start    = st[1];
  assign bus4.data_in  = din[1][3:0];

  assign busy_o[0] = bus16.busy;
  assign busy_o[1] = bus4.busy;
  assign done_o[0] = bus16.done;
  assign done_o[1] = bus4.done;
  assign res_o[0]  = 32'(bus16.result);
  assign res_o[1]  = 32'(bus4.result);
`ifdef GCD_ITER_COUNT_EN
  assign iter_o[0] = 32'(bus16.iter_count);
  assign iter_o[1] = 32'(bus4.iter_count);
`else
  assign iter_o[0] = 0;
  assign iter_o[1] = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned msk(input int i);
    return (i == 0) ? MASK0 : MASK1;
  endfunction

  // gcd via Euclid; subtraction count = sum of quotients minus one
  function automatic void gcd_model(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned s);
    int unsigned x, y, t;
    if (a == 0 || b == 0) begin
      g = a + b;
      s = 0;
      return;
    end
    x = a; y = b; s = 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    s = s - 1;
  endfunction

  // Timeline model: start edge k, subtraction count S, result g
  int          edges = 0;
  bit          m_act  [2] = '{0, 0};
  bit          m_have [2] = '{0, 0};
  int          m_k    [2];
  int unsigned m_a    [2];
  int unsigned m_s    [2];
  int unsigned m_g    [2];
  int unsigned m_res  [2] = '{0, 0};

  always @(posedge clk) begin
    edges++;
    for (int i = 0; i < 2; i++) begin
      bit idle;
      if (rst) begin
        m_act[i]  = 0;
        m_have[i] = 0;
        m_res[i]  = 0;
      end else begin
        idle = !m_act[i] ||
               (m_have[i] && (edges - 1 >= m_k[i] + 3 + int'(m_s[i])));
        if (idle && st[i]) begin
          m_act[i]  = 1;
          m_have[i] = 0;
          m_k[i]    = edges;
          m_a[i]    = 32'(din[i]) & msk(i);
        end else if (m_act[i] && !m_have[i] && edges == m_k[i] + 1) begin
          gcd_model(m_a[i], 32'(din[i]) & msk(i), m_g[i], m_s[i]);
          m_have[i] = 1;
        end
        if (m_act[i] && m_have[i] && edges == m_k[i] + 2 + int'(m_s[i]))
          m_res[i] = m_g[i];
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        int unsigned e_busy, e_done, e_iter, cnt;
        e_busy = (m_act[i] && (!m_have[i] || edges <= m_k[i] + 1 + int'(m_s[i]))) ? 1 : 0;
        e_done = (m_act[i] && m_have[i] && edges == m_k[i] + 2 + int'(m_s[i])) ? 1 : 0;
        e_iter = 0;
        if (m_act[i] && edges > m_k[i] + 1) begin
          cnt    = 32'(edges - m_k[i] - 1);
          e_iter = (cnt < m_s[i]) ? cnt : m_s[i];
          if (e_iter > msk(i)) e_iter = msk(i);
        end
        chk($sformatf("cyc%0d.busy[%0d]", edges, i), 32'(busy_o[i]), e_busy);
        chk($sformatf("cyc%0d.done[%0d]", edges, i), 32'(done_o[i]), e_done);
        chk($sformatf("cyc%0d.result[%0d]", edges, i), res_o[i], m_res[i]);
`ifdef GCD_ITER_COUNT_EN
        chk($sformatf("cyc%0d.iter[%0d]", edges, i), iter_o[i], e_iter);
`endif
      end
    end
  end

  // One computation with hand-computed result, latency (edges incl. start), iterations, busy cycles
  task automatic run(input int i, input int unsigned a, input int unsigned b,
                     input int unsigned er, input int unsigned el,
                     input int unsigned ei, input int unsigned eb);
    int unsigned lat, nb;
    bit got;
    @(negedge clk);
    st[i]  = 1'b1;
    din[i] = 16'(a);
    @(negedge clk);
    st[i]  = 1'b0;
    din[i] = 16'(b);
    lat = 1;
    nb  = 32'(busy_o[i]);
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (busy_o[i]) nb++;
      if (done_o[i]) got = 1'b1;
    end
    chk($sformatf("run(%0d,%0d).done_seen", a, b), 32'(got), 1);
    chk($sformatf("run(%0d,%0d).latency", a, b), lat, el);
    chk($sformatf("run(%0d,%0d).result", a, b), res_o[i], er);
    chk($sformatf("run(%0d,%0d).busy_cycles", a, b), nb, eb);
`ifdef GCD_ITER_COUNT_EN
    chk($sformatf("run(%0d,%0d).iter", a, b), iter_o[i], ei);
`else
    if (ei != ei) $display("unreachable");
`endif
  endtask

  initial begin
    rst    = 1'b1;
    st     = '{1'b0, 1'b0};
    din    = '{16'd0, 16'd0};
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("reset.busy", 32'(busy_o[0]), 0);
    chk("reset.done", 32'(done_o[0]), 0);
    chk("reset.result", res_o[0], 0);
    chk("reset.iter", iter_o[0], 0);
    rst = 1'b0;

    run(0, 5, 6, 1, 8, 5, 7);
    run(0, 48, 18, 6, 7, 4, 6);
    run(0, 0, 7, 7, 3, 0, 2);
    run(0, 0, 0, 0, 3, 0, 2);
    run(0, 9, 9, 9, 3, 0, 2);

    // start presented during DONE must be ignored
    st[0]  = 1'b1;
    din[0] = 16'd3;
    @(negedge clk);
    st[0]  = 1'b0;
    chk("start_in_done.busy", 32'(busy_o[0]), 0);
    chk("start_in_done.result", res_o[0], 9);

    // reset in the middle of a long computation
    @(negedge clk);
    st[0]  = 1'b1;
    din[0] = 16'd100;
    @(negedge clk);
    st[0]  = 1'b0;
    din[0] = 16'd1;
    repeat (5) @(negedge clk);
    chk("mid_calc.busy", 32'(busy_o[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("after_rst.busy", 32'(busy_o[0]), 0);
    chk("after_rst.done", 32'(done_o[0]), 0);
    chk("after_rst.result", res_o[0], 0);
    chk("after_rst.iter", iter_o[0], 0);

    run(0, 12, 8, 4, 5, 2, 4);
    run(1, 15, 1, 1, 17, 14, 16);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
